// File: rtl/sht40_pkg.sv
// Shared types and constants for the SHT40 measurement sequencer.
package sht40_pkg;

    // State encodings kept as plain constants so older netlists and
    // debug scripts that decode the raw 3-bit state keep working.
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SEND_CMD  = 3'd1;
    localparam logic [2:0] ST_WAIT_CMD  = 3'd2;
    localparam logic [2:0] ST_CONVERT   = 3'd3;
    localparam logic [2:0] ST_SEND_READ = 3'd4;
    localparam logic [2:0] ST_WAIT_READ = 3'd5;
    localparam logic [2:0] ST_BACKOFF   = 3'd6;
    localparam logic [2:0] ST_FAULT     = 3'd7;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        SEND_CMD  = ST_SEND_CMD,
        WAIT_CMD  = ST_WAIT_CMD,
        CONVERT   = ST_CONVERT,
        SEND_READ = ST_SEND_READ,
        WAIT_READ = ST_WAIT_READ,
        BACKOFF   = ST_BACKOFF,
        FAULT     = ST_FAULT
    } sht40_state_e;

    // Sensor measure commands, one per repeatability setting.
    localparam logic [7:0] CMD_HI  = 8'hFD;
    localparam logic [7:0] CMD_MED = 8'hF6;
    localparam logic [7:0] CMD_LO  = 8'hE0;

    localparam logic [6:0] SHT40_ADDR = 7'h44;

    // precision_sel codes; 2'b11 is treated as high precision.
    localparam logic [1:0] PREC_HI  = 2'b00;
    localparam logic [1:0] PREC_MED = 2'b01;
    localparam logic [1:0] PREC_LO  = 2'b10;

    function automatic logic [7:0] prec_to_cmd(input logic [1:0] prec);
        logic [7:0] cmd;
        case (prec)
            PREC_MED: cmd = CMD_MED;
            PREC_LO:  cmd = CMD_LO;
            default:  cmd = CMD_HI;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/sht40_cycle_timer.sv
// Shared 32-bit down-counter used for conversion, back-off and timeout waits.
module sht40_cycle_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_value,
    output logic        expired
);

    logic [31:0] cnt_q;

    // Count down from the loaded value and park at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_value;
        end else if (cnt_q != 32'd0) begin
            cnt_q <= cnt_q - 32'd1;
        end
    end

    // Terminal count at one, so a load of N flags expiry exactly N cycles
    // after the load cycle and only once. A load of zero never expires.
    assign expired = (cnt_q == 32'd1);

endmodule

// File: rtl/sht40_meas_ctrl.sv
// SHT40 measurement sequencer: issues the measure command, waits out the
// conversion, issues the 6-byte read and supervises the parser flags.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a pending request
// SEND_CMD  | one-cycle write start carrying the measure command
// WAIT_CMD  | waiting for the write to finish (timeout armed)
// CONVERT   | waiting out the sensor conversion time
// SEND_READ | one-cycle read start
// WAIT_READ | waiting for Temp and RH ready edges (timeout armed)
// BACKOFF   | delay before retrying from SEND_CMD
// FAULT     | retries exhausted; sticky until fault_clr
module sht40_meas_ctrl
    import sht40_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES  = 50_000_000,
    parameter int unsigned CONV_HI        = 500_000,
    parameter int unsigned CONV_MED       = 250_000,
    parameter int unsigned CONV_LO        = 100_000,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned BACKOFF_CYCLES = 50_000,
    parameter int unsigned MAX_RETRY      = 3,
    parameter logic [6:0]  SENSOR_ADDR    = SHT40_ADDR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       meas_trigger,
    input  logic [1:0] precision_sel,
    input  logic       fault_clr,
    output logic       i2c_start,
    output logic       i2c_rw,
    output logic [6:0] i2c_addr,
    output logic [7:0] i2c_wdata,
    input  logic       i2c_done,
    input  logic       i2c_nack,
    input  logic       temp_ready,
    input  logic       rh_ready,
    input  logic       crc_error,
    output logic       busy,
    output logic       sample_valid,
    output logic       fault,
    output logic [1:0] retry_cnt
);

    sht40_state_e state_q, state_d;

    logic [31:0] period_cnt_q;
    logic        period_wrap;
    logic        pending_q;
    logic [1:0]  prec_q;
    logic [1:0]  retry_q;
    logic        seen_t_q, seen_rh_q;
    logic        seen_t_n, seen_rh_n;
    logic        temp_q, rh_q;
    logic        fault_q;
    logic        sample_valid_q;

    logic        tmr_load;
    logic [31:0] tmr_value;
    logic        tmr_expired;
    logic [31:0] conv_cycles;

    logic        start_meas;
    logic        clr_seen;
    logic        fail;
    logic        complete;
    logic        retry_inc;
    logic        enter_fault;
    logic        leave_fault;

    sht40_cycle_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (tmr_load),
        .load_value (tmr_value),
        .expired    (tmr_expired)
    );

    assign period_wrap = enable && (period_cnt_q == PERIOD_CYCLES - 1);

    // Periodic request counter; parked at zero while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_cnt_q <= '0;
        end else if (!enable || period_wrap) begin
            period_cnt_q <= '0;
        end else begin
            period_cnt_q <= period_cnt_q + 32'd1;
        end
    end

    // One-deep request latch; a new request in the consuming cycle is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= 1'b0;
        end else if (meas_trigger || period_wrap) begin
            pending_q <= 1'b1;
        end else if (start_meas) begin
            pending_q <= 1'b0;
        end
    end

    // Previous-cycle copies of the parser ready levels for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            temp_q <= 1'b0;
            rh_q   <= 1'b0;
        end else begin
            temp_q <= temp_ready;
            rh_q   <= rh_ready;
        end
    end

    assign seen_t_n  = seen_t_q  | (temp_ready & ~temp_q);
    assign seen_rh_n = seen_rh_q | (rh_ready & ~rh_q);

    // Conversion wait for the precision latched at measurement start.
    always_comb begin
        case (prec_q)
            PREC_MED: conv_cycles = CONV_MED;
            PREC_LO:  conv_cycles = CONV_LO;
            default:  conv_cycles = CONV_HI;
        endcase
    end

    // Next-state logic; failure handling overrides any completion.
    always_comb begin
        state_d     = state_q;
        tmr_load    = 1'b0;
        tmr_value   = '0;
        start_meas  = 1'b0;
        clr_seen    = 1'b0;
        fail        = 1'b0;
        complete    = 1'b0;
        retry_inc   = 1'b0;
        enter_fault = 1'b0;
        leave_fault = 1'b0;

        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    start_meas = 1'b1;
                    state_d    = SEND_CMD;
                end
            end
            SEND_CMD: begin
                tmr_load  = 1'b1;
                tmr_value = TIMEOUT_CYCLES;
                state_d   = WAIT_CMD;
            end
            WAIT_CMD: begin
                if (i2c_nack || tmr_expired) begin
                    fail = 1'b1;
                end else if (i2c_done) begin
                    tmr_load  = 1'b1;
                    tmr_value = conv_cycles;
                    state_d   = CONVERT;
                end
            end
            CONVERT: begin
                if (tmr_expired) begin
                    state_d = SEND_READ;
                end
            end
            SEND_READ: begin
                tmr_load  = 1'b1;
                tmr_value = TIMEOUT_CYCLES;
                clr_seen  = 1'b1;
                state_d   = WAIT_READ;
            end
            WAIT_READ: begin
                if (crc_error || i2c_nack || tmr_expired) begin
                    fail = 1'b1;
                end else if (seen_t_n && seen_rh_n) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            BACKOFF: begin
                if (tmr_expired) begin
                    state_d = SEND_CMD;
                end
            end
            FAULT: begin
                if (fault_clr) begin
                    leave_fault = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (fail) begin
            if (32'(retry_q) < MAX_RETRY) begin
                retry_inc = 1'b1;
                tmr_load  = 1'b1;
                tmr_value = BACKOFF_CYCLES;
                state_d   = BACKOFF;
            end else begin
                enter_fault = 1'b1;
                state_d     = FAULT;
            end
        end
    end

    // Sequencer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            prec_q         <= PREC_HI;
            retry_q        <= '0;
            seen_t_q       <= 1'b0;
            seen_rh_q      <= 1'b0;
            fault_q        <= 1'b0;
            sample_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sample_valid_q <= complete;

            if (start_meas) begin
                prec_q  <= precision_sel;
                retry_q <= '0;
            end else if (retry_inc) begin
                retry_q <= retry_q + 2'd1;
            end

            if (clr_seen) begin
                seen_t_q  <= 1'b0;
                seen_rh_q <= 1'b0;
            end else if (state_q == WAIT_READ) begin
                seen_t_q  <= seen_t_n;
                seen_rh_q <= seen_rh_n;
            end

            if (enter_fault) begin
                fault_q <= 1'b1;
            end else if (leave_fault) begin
                fault_q <= 1'b0;
            end
        end
    end

    // Start is decoded from state so reset drops it in the same instant.
    assign i2c_start    = (state_q == SEND_CMD) || (state_q == SEND_READ);
    assign i2c_rw       = (state_q == SEND_READ);
    assign i2c_addr     = SENSOR_ADDR;
    assign i2c_wdata    = (state_q == SEND_CMD) ? prec_to_cmd(prec_q) : 8'h00;
    assign busy         = (state_q != IDLE) && (state_q != FAULT);
    assign sample_valid = sample_valid_q;
    assign fault        = fault_q;
    assign retry_cnt    = retry_q;

endmodule

// File: tb/tb_sht40_meas_ctrl.sv
// Scoreboard bench for sht40_meas_ctrl: randomized bus/parser responses, a
// timing model that predicts every start, sample and fault event.
module tb_sht40_meas_ctrl;

    localparam int PER  = 1000;
    localparam int CHI  = 100;
    localparam int CMED = 50;
    localparam int CLO  = 30;
    localparam int TMO  = 400;
    localparam int BOF  = 20;
    localparam int MAXR = 3;

    localparam int EV_W = 0;
    localparam int EV_R = 1;
    localparam int EV_V = 2;
    localparam int EV_F = 3;

    logic       clk, rst, enable, meas_trigger, fault_clr;
    logic [1:0] precision_sel;
    logic       i2c_start, i2c_rw;
    logic [6:0] i2c_addr;
    logic [7:0] i2c_wdata;
    logic       i2c_done, i2c_nack, temp_ready, rh_ready, crc_error;
    logic       busy, sample_valid, fault;
    logic [1:0] retry_cnt;

    sht40_meas_ctrl #(
        .PERIOD_CYCLES  (PER),
        .CONV_HI        (CHI),
        .CONV_MED       (CMED),
        .CONV_LO        (CLO),
        .TIMEOUT_CYCLES (TMO),
        .BACKOFF_CYCLES (BOF),
        .MAX_RETRY      (MAXR),
        .SENSOR_ADDR    (7'h44)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .meas_trigger  (meas_trigger),
        .precision_sel (precision_sel),
        .fault_clr     (fault_clr),
        .i2c_start     (i2c_start),
        .i2c_rw        (i2c_rw),
        .i2c_addr      (i2c_addr),
        .i2c_wdata     (i2c_wdata),
        .i2c_done      (i2c_done),
        .i2c_nack      (i2c_nack),
        .temp_ready    (temp_ready),
        .rh_ready      (rh_ready),
        .crc_error     (crc_error),
        .busy          (busy),
        .sample_valid  (sample_valid),
        .fault         (fault),
        .retry_cnt     (retry_cnt)
    );

    typedef struct {
        int kind;
        int wdata;
        int retry;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    // Response tables. Write kind: 0 done, 1 nack, 2 silent.
    // Read kind: 0 good, 1 crc error, 2 silent, 3 nack.
    int w_kind[256], w_lat[256];
    int r_kind[256], r_tl[256], r_hl[256], r_cl[256], r_dl[256];
    int fw = 0, fr = 0;       // fill pointers
    int mw = 0, mr = 0;       // model pointers
    int rw_i = 0, rr_i = 0;   // responder pointers

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation still running at cycle %0d, want finished", cyc);
        $fatal(1, "watchdog");
    end

    function automatic int conv_of(input logic [1:0] p);
        if (p == 2'b01) return CMED;
        if (p == 2'b10) return CLO;
        return CHI;
    endfunction

    function automatic int cmd_of(input logic [1:0] p);
        if (p == 2'b01) return 8'hF6;
        if (p == 2'b10) return 8'hE0;
        return 8'hFD;
    endfunction

    task automatic push_exp(input int kind, input int wdata, input int retry, input int c);
        exp_t e;
        e.kind = kind; e.wdata = wdata; e.retry = retry; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic add_w(input int k, input int lat);
        w_kind[fw] = k;
        w_lat[fw]  = lat;
        fw++;
    endtask

    task automatic add_r(input int k);
        int tl, hl, mx;
        tl = $urandom_range(2, 30);
        hl = $urandom_range(2, 30);
        mx = (tl > hl) ? tl : hl;
        r_kind[fr] = k;
        r_tl[fr]   = tl;
        r_hl[fr]   = hl;
        r_cl[fr]   = (k == 1) ? $urandom_range(1, mx) : $urandom_range(1, 20);
        r_dl[fr]   = $urandom_range(1, tl);
        fr++;
    endtask

    task automatic add_good();
        add_w(0, $urandom_range(1, 40));
        add_r(0);
    endtask

    task automatic add_random_fail();
        case ($urandom_range(0, 4))
            0: add_w(1, $urandom_range(1, 30));
            1: add_w(2, 0);
            2: begin add_w(0, $urandom_range(1, 40)); add_r(1); end
            3: begin add_w(0, $urandom_range(1, 40)); add_r(3); end
            default: begin add_w(0, $urandom_range(1, 40)); add_r(2); end
        endcase
    endtask

    // Predict one measurement whose first write start is in cycle s.
    // idle_at is the cycle the sequencer is back in IDLE (-1 after a fault).
    task automatic model_meas(input int s, input logic [1:0] prec, output int idle_at);
        int  t, f, r, rs, c, wi, ri, conv, cmd;
        bit  fin;
        conv = conv_of(prec);
        cmd  = cmd_of(prec);
        t = s; r = 0; f = 0; fin = 0; idle_at = -1;
        while (!fin) begin
            push_exp(EV_W, cmd, r, t);
            wi = mw; mw++;
            if (w_kind[wi] == 0) begin
                // Conversion timer runs conv cycles from the done pulse,
                // the read start follows in the next cycle.
                rs = t + w_lat[wi] + conv + 1;
                push_exp(EV_R, 0, r, rs);
                ri = mr; mr++;
                if (r_kind[ri] == 0) begin
                    c = rs + ((r_tl[ri] > r_hl[ri]) ? r_tl[ri] : r_hl[ri]);
                    push_exp(EV_V, 0, r, c + 1);
                    idle_at = c + 1;
                    fin = 1;
                end else if (r_kind[ri] == 2) begin
                    f = rs + TMO;
                end else begin
                    f = rs + r_cl[ri];
                end
            end else if (w_kind[wi] == 1) begin
                f = t + w_lat[wi];
            end else begin
                f = t + TMO;
            end
            if (!fin) begin
                if (r < MAXR) begin
                    r++;
                    t = f + BOF + 1;
                end else begin
                    push_exp(EV_F, 0, r, f + 1);
                    fin = 1;
                end
            end
        end
    endtask

    // I2C master and response parser stand-in.
    int wc, tc, hc, cc, dc, cur_w, cur_r;
    initial begin
        i2c_done = 0; i2c_nack = 0; temp_ready = 0; rh_ready = 0; crc_error = 0;
        wc = 0; tc = 0; hc = 0; cc = 0; dc = 0; cur_w = 0; cur_r = 0;
        forever begin
            @(negedge clk);
            i2c_done = 0;
            i2c_nack = 0;
            if (wc > 0) begin
                wc--;
                if (wc == 0) begin
                    if (w_kind[cur_w] == 0) i2c_done = 1; else i2c_nack = 1;
                end
            end
            if (tc > 0) begin tc--; if (tc == 0) temp_ready = 1; end
            if (hc > 0) begin hc--; if (hc == 0) rh_ready = 1; end
            if (cc > 0) begin
                cc--;
                if (cc == 0) begin
                    if (r_kind[cur_r] == 1) crc_error = 1; else i2c_nack = 1;
                end
            end
            if (dc > 0) begin dc--; if (dc == 0) i2c_done = 1; end
            if (i2c_start && !rst) begin
                temp_ready = 0; rh_ready = 0; crc_error = 0;
                wc = 0; tc = 0; hc = 0; cc = 0; dc = 0;
                if (!i2c_rw) begin
                    cur_w = rw_i; rw_i++;
                    if (w_kind[cur_w] != 2) wc = w_lat[cur_w];
                end else begin
                    cur_r = rr_i; rr_i++;
                    case (r_kind[cur_r])
                        0: begin tc = r_tl[cur_r]; hc = r_hl[cur_r]; dc = r_dl[cur_r]; end
                        1: begin tc = r_tl[cur_r]; hc = r_hl[cur_r]; cc = r_cl[cur_r]; dc = r_dl[cur_r]; end
                        3: cc = r_cl[cur_r];
                        default: ;
                    endcase
                end
            end
        end
    end

    task automatic observe(input int kind);
        exp_t e;
        bit   ok;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: got kind=%0d at cycle %0d retry=%0d wdata=%02h, want no event",
                     kind, cyc, retry_cnt, i2c_wdata);
            return;
        end
        e = exp_q.pop_front();
        ok = (e.kind == kind) && (e.cyc == cyc) && (int'(retry_cnt) == e.retry);
        if (kind == EV_W)
            ok = ok && (int'(i2c_wdata) == e.wdata) && (i2c_addr == 7'h44);
        if (!ok) begin
            errors++;
            $display("FAIL event: got kind=%0d cycle=%0d retry=%0d wdata=%02h addr=%02h, want kind=%0d cycle=%0d retry=%0d wdata=%02h addr=44",
                     kind, cyc, retry_cnt, i2c_wdata, i2c_addr, e.kind, e.cyc, e.retry, e.wdata);
        end
    endtask

    // Monitor: every start, sample pulse and fault rise is matched in order.
    logic fault_prev;
    initial begin
        fault_prev = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (i2c_start) observe(i2c_rw ? EV_R : EV_W);
                if (sample_valid) observe(EV_V);
                if (fault && !fault_prev) observe(EV_F);
            end
            fault_prev = fault;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic wait_empty(input string tag, input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d predicted events still outstanding after %0d cycles, want 0",
                     tag, exp_q.size(), limit);
            exp_q.delete();
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic trigger(output int g);
        @(negedge clk);
        g = cyc;
        meas_trigger = 1;
        @(negedge clk);
        meas_trigger = 0;
    endtask

    task automatic pulse_trigger_at(input int c);
        wait_cyc(c);
        meas_trigger = 1;
        @(negedge clk);
        meas_trigger = 0;
    endtask

    initial begin
        int g, s, e, h, idle1, idle2, nf;
        logic [1:0] p;
        rst = 1; enable = 0; meas_trigger = 0; fault_clr = 0; precision_sel = 2'b00;
        repeat (3) @(negedge clk);
        chk("reset i2c_start", i2c_start, 0);
        chk("reset i2c_rw", i2c_rw, 0);
        chk("reset i2c_addr", i2c_addr, 'h44);
        chk("reset i2c_wdata", i2c_wdata, 0);
        chk("reset busy", busy, 0);
        chk("reset sample_valid", sample_valid, 0);
        chk("reset fault", fault, 0);
        chk("reset retry_cnt", retry_cnt, 0);
        rst = 0;
        repeat (5) @(negedge clk);

        // Single shot, high precision, write done 30 cycles after start.
        precision_sel = 2'b00;
        add_w(0, 30); add_r(0);
        trigger(g);
        model_meas(g + 2, 2'b00, idle1);
        repeat (10) @(negedge clk);
        fault_clr = 1;                      // no effect outside FAULT
        @(negedge clk);
        fault_clr = 0;
        chk("single busy mid", busy, 1);
        wait_empty("single", 1000);
        chk("single retry_cnt", retry_cnt, 0);
        chk("single fault", fault, 0);

        // Periodic mode, medium precision.
        repeat (20) @(negedge clk);
        precision_sel = 2'b01;
        repeat (3) add_good();
        @(negedge clk);
        e = cyc;
        enable = 1;
        for (int k = 1; k <= 3; k++) model_meas(e + k * PER + 1, 2'b01, idle1);
        wait_cyc(e + 3500);
        enable = 0;
        wait_empty("periodic", 2000);
        repeat (1100) @(negedge clk);
        chk("periodic busy after disable", busy, 0);

        // CRC error on the first read, good second read.
        precision_sel = 2'b00;
        add_w(0, $urandom_range(1, 40)); add_r(1);
        add_good();
        trigger(g);
        model_meas(g + 2, 2'b00, idle1);
        wait_empty("crc_retry", 2000);
        chk("crc_retry retry_cnt", retry_cnt, 1);

        // NACK on every write: three retries then fault.
        repeat (4) add_w(1, $urandom_range(1, 20));
        trigger(g);
        model_meas(g + 2, 2'b00, idle1);
        wait_empty("fault_entry", 2000);
        @(negedge clk);
        chk("fault flag", fault, 1);
        chk("fault busy", busy, 0);
        chk("fault retry_cnt", retry_cnt, 3);
        trigger(g);
        repeat (30) @(negedge clk);
        chk("fault holds busy", busy, 0);
        chk("fault holds flag", fault, 1);
        add_good();
        @(negedge clk);
        h = cyc;
        fault_clr = 1;
        @(negedge clk);
        fault_clr = 0;
        model_meas(h + 2, 2'b00, idle1);
        chk("fault_clr clears", fault, 0);
        wait_empty("after_fault_clr", 1000);

        // Write never answered: timeout, then merged triggers during busy.
        repeat (10) @(negedge clk);
        precision_sel = 2'b11;
        add_w(2, 0);
        add_good();
        add_good();
        trigger(g);
        s = g + 2;
        model_meas(s, 2'b11, idle1);
        model_meas(idle1 + 1, 2'b11, idle2);
        pulse_trigger_at(s + 50);
        pulse_trigger_at(s + 200);
        pulse_trigger_at(s + 430);
        wait_empty("timeout_merge", 3000);
        repeat (300) @(negedge clk);
        chk("merge busy after", busy, 0);

        // Reset in the middle of the conversion wait.
        precision_sel = 2'b10;
        add_w(0, 10);
        trigger(g);
        s = g + 2;
        push_exp(EV_W, 8'hE0, 0, s);
        mw++;
        wait_cyc(s + 25);
        rst = 1;
        #1;
        chk("midreset i2c_start", i2c_start, 0);
        chk("midreset busy", busy, 0);
        chk("midreset retry_cnt", retry_cnt, 0);
        chk("midreset sample_valid", sample_valid, 0);
        chk("midreset i2c_wdata", i2c_wdata, 0);
        @(negedge clk);
        rst = 0;
        repeat (100) @(negedge clk);
        wait_empty("midreset_no_read", 1);
        add_good();
        trigger(g);
        model_meas(g + 2, 2'b10, idle1);
        wait_empty("after_reset", 1000);

        // Randomized measurements with up to three failures each.
        for (int i = 0; i < 6; i++) begin
            p = 2'($urandom_range(0, 3));
            nf = $urandom_range(0, 3);
            for (int j = 0; j < nf; j++) add_random_fail();
            add_good();
            precision_sel = p;
            trigger(g);
            model_meas(g + 2, p, idle1);
            wait_empty("random", 4000);
            chk("random retry_cnt", retry_cnt, nf);
            repeat ($urandom_range(1, 20)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
